// File: rtl/pkt_hdr_size_parser_w.sv
// pkt_hdr_size_parser_w: beat-streamed Eth/IPv4/UDP/TCP header-size parser; define VLAN_PARSE_EN to parse one 802.1Q tag
module pkt_hdr_size_parser_w #(
  parameter int BUS_W_B = 8,
  parameter int CNT_W   = 16
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic [BUS_W_B*8-1:0]       bus_i,
  input  logic                       valid_i,
  input  logic                       sop_i,
  input  logic                       eop_i,
  input  logic [$clog2(BUS_W_B):0]   last_bytes_i,
  output logic                       phs_valid_o,
  output logic [CNT_W-1:0]           phs_o,
  output logic [CNT_W-1:0]           pay_last_word_o,
  output logic [$clog2(BUS_W_B)-1:0] pay_off_o,
  output logic                       err_o
);
  localparam int LW = $clog2(BUS_W_B);
  if (BUS_W_B != 4 && BUS_W_B != 8 && BUS_W_B != 16) begin : g_bad_width
    $error("pkt_hdr_size_parser_w: BUS_W_B must be 4, 8 or 16");
  end
  typedef enum logic [1:0] {IDLE, FIX, L4, DRAIN} state_t;
  state_t state, state_n;
  logic [7:0] lanes [BUS_W_B];
  logic [CNT_W-1:0] base_q, cur_base, l2, l3_n, l3_q, target_n, target_q, fix_phs, l4_phs, res_phs;
  logic [CNT_W:0] avail_end, base_sum;
  logic [7:0] c12, c13, c14, c23, n12, n13, n14, n23, proto;
  logic [15:0] etype;
  logic [3:0] ihl, off;
  logic vlan, is_ip, fix_ready, fix_err, fix_tcp, fix_beat, l4_beat, l4_ready, fix_done, l4_done, res_v, res_err;
`ifdef VLAN_PARSE_EN
  logic [7:0] c16, c17, c18, c27, n16, n17, n18, n27;
`endif
  function automatic logic [7:0] pick(input logic [CNT_W-1:0] idx, input logic [7:0] old);
    return (valid_i && (idx >> LW) == (cur_base >> LW)) ? lanes[idx[LW-1:0]] : old;
  endfunction
  function automatic logic reached(input logic [CNT_W-1:0] idx);
    return valid_i && ({1'b0, idx} < avail_end);
  endfunction
  // Split the beat into byte lanes and locate it in the packet (a sop beat is always beat 0)
  always_comb begin
    for (int k = 0; k < BUS_W_B; k++) lanes[k] = bus_i[(BUS_W_B-1-k)*8 +: 8];
    cur_base = sop_i ? '0 : base_q;
    avail_end = {1'b0, cur_base} + (eop_i ? (CNT_W+1)'(last_bytes_i) : (CNT_W+1)'(BUS_W_B));
    base_sum = {1'b0, cur_base} + (CNT_W+1)'(BUS_W_B);
  end
  // Merge in-flight bytes with captured ones and decide the header size as soon as the deciding byte arrives
  always_comb begin
    n12 = pick(CNT_W'(12), c12);
    n13 = pick(CNT_W'(13), c13);
    n14 = pick(CNT_W'(14), c14);
    n23 = pick(CNT_W'(23), c23);
`ifdef VLAN_PARSE_EN
    n16 = pick(CNT_W'(16), c16);
    n17 = pick(CNT_W'(17), c17);
    n18 = pick(CNT_W'(18), c18);
    n27 = pick(CNT_W'(27), c27);
    vlan = {n12, n13} == 16'h8100;
    etype = vlan ? {n16, n17} : {n12, n13};
    ihl = vlan ? n18[3:0] : n14[3:0];
    proto = vlan ? n27 : n23;
`else
    vlan = 1'b0;
    etype = {n12, n13};
    ihl = n14[3:0];
    proto = n23;
`endif
    is_ip = etype == 16'h0800;
    l2 = vlan ? CNT_W'(18) : CNT_W'(14);
    l3_n = l2 + CNT_W'({ihl, 2'b00});
    target_n = l3_n + CNT_W'(12);
    fix_ready = reached(CNT_W'(13)) && (!vlan || reached(CNT_W'(17))) && (!is_ip || reached(l2 + CNT_W'(9)));
    fix_err = is_ip && ihl < 4'd5;
    fix_tcp = is_ip && !fix_err && proto == 8'd6;
    fix_phs = (!is_ip || fix_err) ? l2 : (proto == 8'd17) ? l3_n + CNT_W'(8) : l3_n;
    off = lanes[target_q[LW-1:0]][7:4];
    l4_ready = reached(target_q);
    l4_phs = (off < 4'd5) ? l3_q + CNT_W'(20) : l3_q + CNT_W'({off, 2'b00});
    fix_beat = valid_i && (sop_i || state == FIX);
    l4_beat = valid_i && !sop_i && state == L4;
    fix_done = fix_beat && fix_ready && !fix_tcp;
    l4_done = l4_beat && l4_ready;
  end
  // State register
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // Next state; any eop beat ends the packet, any sop beat restarts collection
  always_comb begin
    state_n = state;
    if (fix_beat) state_n = eop_i ? IDLE : !fix_ready ? FIX : fix_tcp ? L4 : DRAIN;
    else if (l4_beat) state_n = eop_i ? IDLE : l4_ready ? DRAIN : L4;
    else if (valid_i && state == DRAIN && eop_i) state_n = IDLE;
  end
  // Result selection; an eop before the decision reports the bytes actually seen as a truncation
  always_comb begin
    res_v = fix_done || l4_done || ((fix_beat || l4_beat) && eop_i);
    res_phs = fix_done ? fix_phs : l4_done ? l4_phs : avail_end[CNT_W-1:0];
    res_err = fix_done ? fix_err : l4_done ? (off < 4'd5) : 1'b1;
  end
  // Beat position, speculative fixed-offset captures and TCP offset-byte target
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      base_q <= '0;
      {c12, c13, c14, c23} <= '0;
`ifdef VLAN_PARSE_EN
      {c16, c17, c18, c27} <= '0;
`endif
      l3_q <= '0;
      target_q <= '0;
    end else begin
      if (valid_i) base_q <= base_sum[CNT_W] ? '1 : base_sum[CNT_W-1:0];
      {c12, c13, c14, c23} <= {n12, n13, n14, n23};
`ifdef VLAN_PARSE_EN
      {c16, c17, c18, c27} <= {n16, n17, n18, n27};
`endif
      if (fix_beat) begin
        l3_q <= l3_n;
        target_q <= target_n;
      end
    end
  end
  // Registered result pulse; fields hold until the next pulse
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      phs_valid_o <= 1'b0;
      phs_o <= '0;
      err_o <= 1'b0;
    end else begin
      phs_valid_o <= res_v;
      if (res_v) begin
        phs_o <= res_phs;
        err_o <= res_err;
      end
    end
  end
  assign pay_last_word_o = phs_o >> LW;
  assign pay_off_o = phs_o[LW-1:0];
endmodule

// File: tb/tb_pkt_hdr_size_parser_w.sv
// tb_pkt_hdr_size_parser_w: directed checks of the header-size parser at 4, 8 and 16 byte bus widths
module tb_pkt_hdr_size_parser_w;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] bus4 = '0;
  logic [63:0] bus8 = '0;
  logic [127:0] bus16 = '0;
  logic v4 = 1'b0, v8 = 1'b0, v16 = 1'b0, sop = 1'b0, eop = 1'b0;
  logic [2:0] lb4 = '0;
  logic [3:0] lb8 = '0;
  logic [4:0] lb16 = '0;
  logic pv4, pv8, pv16, err4, err8, err16;
  logic [15:0] phs4, phs8, phs16, plw4, plw8, plw16;
  logic [1:0] off4;
  logic [2:0] off8;
  logic [3:0] off16;
  logic [7:0] pkt [128];
  int total = 0, bad = 0, cyc = 0, b0cyc = 0, pcyc16 = -1;
  int np4 = 0, np8 = 0, np16 = 0;
  int q8 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (pv4) np4++;
    if (pv8) begin np8++; q8.push_back(int'(phs8)); end
    if (pv16) begin np16++; pcyc16 = cyc; end
  end

  pkt_hdr_size_parser_w #(.BUS_W_B(4), .CNT_W(16)) u4 (.CLK(clk), .reset(rst), .bus_i(bus4), .valid_i(v4), .sop_i(sop), .eop_i(eop), .last_bytes_i(lb4), .phs_valid_o(pv4), .phs_o(phs4), .pay_last_word_o(plw4), .pay_off_o(off4), .err_o(err4));
  pkt_hdr_size_parser_w #(.BUS_W_B(8), .CNT_W(16)) u8 (.CLK(clk), .reset(rst), .bus_i(bus8), .valid_i(v8), .sop_i(sop), .eop_i(eop), .last_bytes_i(lb8), .phs_valid_o(pv8), .phs_o(phs8), .pay_last_word_o(plw8), .pay_off_o(off8), .err_o(err8));
  pkt_hdr_size_parser_w #(.BUS_W_B(16), .CNT_W(16)) u16 (.CLK(clk), .reset(rst), .bus_i(bus16), .valid_i(v16), .sop_i(sop), .eop_i(eop), .last_bytes_i(lb16), .phs_valid_o(pv16), .phs_o(phs16), .pay_last_word_o(plw16), .pay_off_o(off16), .err_o(err16));

  task automatic build(input bit vl, input logic [15:0] et, input logic [3:0] ihl, input logic [7:0] pr, input logic [3:0] toff);
    int l2, l3;
    for (int i = 0; i < 128; i++) pkt[i] = 8'(i * 7 + 3);
    l2 = vl ? 18 : 14;
    if (vl) begin pkt[12] = 8'h81; pkt[13] = 8'h00; end
    pkt[l2-2] = et[15:8];
    pkt[l2-1] = et[7:0];
    pkt[l2] = {4'h4, ihl};
    pkt[l2+9] = pr;
    l3 = l2 + 4 * int'(ihl);
    pkt[l3+12] = {toff, 4'h0};
  endtask

  task automatic send(input int w, input int len, input int maxb, input bit gap);
    int nb, sb;
    logic [7:0] val;
    nb = (len + w - 1) / w;
    sb = maxb < nb ? maxb : nb;
    for (int b = 0; b < sb; b++) begin
      @(negedge clk);
      for (int k = 0; k < w; k++) begin
        val = (b * w + k < len) ? pkt[b*w+k] : 8'h00;
        if (w == 4) bus4[(3-k)*8 +: 8] = val;
        else if (w == 8) bus8[(7-k)*8 +: 8] = val;
        else bus16[(15-k)*8 +: 8] = val;
      end
      v4 = w == 4; v8 = w == 8; v16 = w == 16;
      sop = b == 0;
      eop = b == nb - 1;
      lb4 = 3'(len - b * w); lb8 = 4'(len - b * w); lb16 = 5'(len - b * w);
      @(posedge clk); #1;
      if (b == 0) b0cyc = cyc;
      if (gap) begin
        @(negedge clk);
        v4 = 1'b0; v8 = 1'b0; v16 = 1'b0;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    v4 = 1'b0; v8 = 1'b0; v16 = 1'b0; sop = 1'b0; eop = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    total++; if (pv8 !== 1'b0) begin bad++; $display("FAIL reset_pv8 got=%0d exp=0", pv8); end
    total++; if (phs8 !== 16'd0) begin bad++; $display("FAIL reset_phs8 got=%0d exp=0", phs8); end
    total++; if (plw8 !== 16'd0) begin bad++; $display("FAIL reset_plw8 got=%0d exp=0", plw8); end
    total++; if (off8 !== 3'd0) begin bad++; $display("FAIL reset_off8 got=%0d exp=0", off8); end
    total++; if (err8 !== 1'b0) begin bad++; $display("FAIL reset_err8 got=%0d exp=0", err8); end
    total++; if ({pv4, phs4, err4} !== 18'd0) begin bad++; $display("FAIL reset_w4 got=%0d exp=0", {pv4, phs4, err4}); end
    total++; if ({pv16, phs16, err16} !== 18'd0) begin bad++; $display("FAIL reset_w16 got=%0d exp=0", {pv16, phs16, err16}); end
    @(negedge clk) rst = 1'b0;
    idle(2);
  endtask

  task automatic test_udp8;
    int n0 = np8;
    build(1'b0, 16'h0800, 4'd5, 8'd17, 4'd0);
    send(8, 57, 99, 1'b0);
    idle(3);
    total++; if (np8 - n0 != 1) begin bad++; $display("FAIL udp_pulses got=%0d exp=1", np8 - n0); end
    total++; if (phs8 !== 16'd42) begin bad++; $display("FAIL udp_phs got=%0d exp=42", phs8); end
    total++; if (plw8 !== 16'd5) begin bad++; $display("FAIL udp_plw got=%0d exp=5", plw8); end
    total++; if (off8 !== 3'd2) begin bad++; $display("FAIL udp_off got=%0d exp=2", off8); end
    total++; if (err8 !== 1'b0) begin bad++; $display("FAIL udp_err got=%0d exp=0", err8); end
  endtask

  task automatic test_tcp4;
    int n0 = np4;
    build(1'b0, 16'h0800, 4'd7, 8'd6, 4'd8);
    send(4, 84, 99, 1'b1);
    idle(3);
    total++; if (np4 - n0 != 1) begin bad++; $display("FAIL tcp4_pulses got=%0d exp=1", np4 - n0); end
    total++; if (phs4 !== 16'd74) begin bad++; $display("FAIL tcp4_phs got=%0d exp=74", phs4); end
    total++; if (plw4 !== 16'd18) begin bad++; $display("FAIL tcp4_plw got=%0d exp=18", plw4); end
    total++; if (off4 !== 2'd2) begin bad++; $display("FAIL tcp4_off got=%0d exp=2", off4); end
    total++; if (err4 !== 1'b0) begin bad++; $display("FAIL tcp4_err got=%0d exp=0", err4); end
  endtask

  task automatic test_arp16;
    int n0 = np16;
    build(1'b0, 16'h0806, 4'd5, 8'd17, 4'd0);
    send(16, 64, 99, 1'b0);
    idle(3);
    total++; if (np16 - n0 != 1) begin bad++; $display("FAIL arp_pulses got=%0d exp=1", np16 - n0); end
    total++; if (pcyc16 != b0cyc) begin bad++; $display("FAIL arp_latency got=%0d exp=%0d", pcyc16, b0cyc); end
    total++; if (phs16 !== 16'd14) begin bad++; $display("FAIL arp_phs got=%0d exp=14", phs16); end
    total++; if (off16 !== 4'd14) begin bad++; $display("FAIL arp_off got=%0d exp=14", off16); end
    total++; if (err16 !== 1'b0) begin bad++; $display("FAIL arp_err got=%0d exp=0", err16); end
  endtask

  task automatic test_vlan8;
    int n0 = np8;
    logic [15:0] exp_phs;
`ifdef VLAN_PARSE_EN
    exp_phs = 16'd46;
`else
    exp_phs = 16'd14;
`endif
    build(1'b1, 16'h0800, 4'd5, 8'd17, 4'd0);
    send(8, 56, 99, 1'b0);
    idle(3);
    total++; if (np8 - n0 != 1) begin bad++; $display("FAIL vlan_pulses got=%0d exp=1", np8 - n0); end
    total++; if (phs8 !== exp_phs) begin bad++; $display("FAIL vlan_phs got=%0d exp=%0d", phs8, exp_phs); end
    total++; if (err8 !== 1'b0) begin bad++; $display("FAIL vlan_err got=%0d exp=0", err8); end
  endtask

  task automatic test_trunc8;
    int n0 = np8;
    build(1'b0, 16'h0800, 4'd5, 8'd6, 4'd5);
    send(8, 20, 99, 1'b0);
    idle(3);
    total++; if (np8 - n0 != 1) begin bad++; $display("FAIL trunc_pulses got=%0d exp=1", np8 - n0); end
    total++; if (phs8 !== 16'd20) begin bad++; $display("FAIL trunc_phs got=%0d exp=20", phs8); end
    total++; if (err8 !== 1'b1) begin bad++; $display("FAIL trunc_err got=%0d exp=1", err8); end
  endtask

  task automatic test_ihl_err8;
    int n0 = np8;
    build(1'b0, 16'h0800, 4'd4, 8'd17, 4'd0);
    send(8, 60, 99, 1'b0);
    idle(3);
    total++; if (np8 - n0 != 1) begin bad++; $display("FAIL ihl_pulses got=%0d exp=1", np8 - n0); end
    total++; if (phs8 !== 16'd14) begin bad++; $display("FAIL ihl_phs got=%0d exp=14", phs8); end
    total++; if (err8 !== 1'b1) begin bad++; $display("FAIL ihl_err got=%0d exp=1", err8); end
  endtask

  task automatic test_abort_sop8;
    int n0 = np8;
    build(1'b0, 16'h0800, 4'd5, 8'd17, 4'd0);
    send(8, 57, 1, 1'b0);
    build(1'b0, 16'h0800, 4'd6, 8'd1, 4'd0);
    send(8, 60, 99, 1'b0);
    idle(3);
    total++; if (np8 - n0 != 1) begin bad++; $display("FAIL abort_pulses got=%0d exp=1", np8 - n0); end
    total++; if (phs8 !== 16'd38) begin bad++; $display("FAIL abort_phs got=%0d exp=38", phs8); end
    total++; if (off8 !== 3'd6) begin bad++; $display("FAIL abort_off got=%0d exp=6", off8); end
    total++; if (err8 !== 1'b0) begin bad++; $display("FAIL abort_err got=%0d exp=0", err8); end
  endtask

  task automatic test_reset_mid8;
    int n0 = np8;
    build(1'b0, 16'h0800, 4'd5, 8'd6, 4'd5);
    send(8, 70, 3, 1'b0);
    @(negedge clk);
    sop = 1'b0; eop = 1'b0; v8 = 1'b1;
    bus8 = {pkt[24], pkt[25], pkt[26], pkt[27], pkt[28], pkt[29], pkt[30], pkt[31]};
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    v8 = 1'b0;
    #1;
    total++; if (phs8 !== 16'd0) begin bad++; $display("FAIL rstmid_phs_clear got=%0d exp=0", phs8); end
    total++; if (pv8 !== 1'b0) begin bad++; $display("FAIL rstmid_pv_clear got=%0d exp=0", pv8); end
    @(negedge clk);
    v8 = 1'b1; sop = 1'b0; eop = 1'b1; lb8 = 4'd8;
    bus8 = {pkt[0], pkt[1], pkt[2], pkt[3], pkt[4], pkt[5], pkt[6], pkt[7]};
    @(posedge clk); #1;
    build(1'b0, 16'h0800, 4'd5, 8'd17, 4'd0);
    send(8, 57, 99, 1'b0);
    idle(3);
    total++; if (np8 - n0 != 1) begin bad++; $display("FAIL rstmid_pulses got=%0d exp=1", np8 - n0); end
    total++; if (phs8 !== 16'd42) begin bad++; $display("FAIL rstmid_phs got=%0d exp=42", phs8); end
  endtask

  task automatic test_back_to_back8;
    int n0 = np8;
    int s0 = q8.size();
    int a, b;
    build(1'b0, 16'h0800, 4'd5, 8'd17, 4'd0);
    send(8, 57, 99, 1'b0);
    build(1'b0, 16'h0800, 4'd5, 8'd6, 4'd6);
    send(8, 70, 99, 1'b0);
    idle(3);
    a = q8.size() > s0 ? q8[s0] : -1;
    b = q8.size() > s0 + 1 ? q8[s0+1] : -1;
    total++; if (np8 - n0 != 2) begin bad++; $display("FAIL b2b_pulses got=%0d exp=2", np8 - n0); end
    total++; if (a != 42) begin bad++; $display("FAIL b2b_first got=%0d exp=42", a); end
    total++; if (b != 58) begin bad++; $display("FAIL b2b_second got=%0d exp=58", b); end
    total++; if (err8 !== 1'b0) begin bad++; $display("FAIL b2b_err got=%0d exp=0", err8); end
  endtask

  initial begin
    test_reset;
    test_udp8;
    test_tcp4;
    test_arp16;
    test_vlan8;
    test_trunc8;
    test_ihl_err8;
    test_abort_sop8;
    test_back_to_back8;
    test_reset_mid8;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
